// File: rtl/uart_rx_framed_if.sv
// Receive-side stream of uart_rx_framed: one frame per beat with its error flags.
// Handshake: a beat transfers on a clk edge where m_valid && m_ready. Once m_valid is high it
// stays high with stable m_data and flags until that transfer. m_ready may change at any time.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic                 m_valid;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_ready;

  modport master (output m_valid, m_data, m_parity_err, m_frame_err, input m_ready);
  modport slave  (input m_valid, m_data, m_parity_err, m_frame_err, output m_ready);
endinterface

// File: rtl/uart_rx_framed.sv
// UART receiver: 16x-style oversampling, 3-sample majority vote per bit, configurable frame
// format, per-frame parity/framing flags, and a first-word-fall-through frame FIFO.
module uart_rx_framed #(
  parameter int CLOCK_RATE_HZ = 100000000,
  parameter int BAUD_RATE     = 9600,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  uart_rx_framed_if.master              m,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state
);
  localparam int DIV_RAW = CLOCK_RATE_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int M       = OVERSAMPLE / 2;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int FW      = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic rx_meta, rx_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  logic [DW-1:0] div_cnt;
  logic          tick;
  assign tick = (div_cnt == DW'(DIV - 1));
  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DW'(1);
  end

  state_t               state;
  logic                 armed;
  logic [SW-1:0]        sub_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] data_sr;
  logic                 parity_err, frame_err;

  logic vote, decide, end_bit, last_stop, frame_err_next, push_req, par_calc;
  assign vote           = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
  assign decide         = (sub_cnt == SW'(M + 1));
  assign end_bit        = (sub_cnt == SW'(OVERSAMPLE - 1));
  assign last_stop      = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_err_next = frame_err | ~vote;
  assign par_calc       = (^data_sr) ^ vote;
  assign push_req       = tick && (state == S_STOP) && decide && last_stop;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      armed      <= 1'b0;
      sub_cnt    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      data_sr    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (tick) begin
      if (state == S_IDLE) begin
        sub_cnt <= '0;
        if (!armed) begin
          armed <= rx_sync;
        end else if (!rx_sync) begin
          state      <= S_START;
          bit_idx    <= '0;
          stop_idx   <= 1'b0;
          parity_err <= 1'b0;
          frame_err  <= 1'b0;
        end
      end else begin
        sub_cnt <= end_bit ? '0 : sub_cnt + SW'(1);
        if (sub_cnt == SW'(M - 1)) s0 <= rx_sync;
        if (sub_cnt == SW'(M))     s1 <= rx_sync;
        if (decide) begin
          case (state)
            S_START:  if (vote) state <= S_IDLE;
            S_DATA:   data_sr <= {vote, data_sr[DATA_BITS-1:1]};
            S_PARITY: parity_err <= (PARITY == 1) ? par_calc : ~par_calc;
            S_STOP: begin
              frame_err <= frame_err_next;
              if (last_stop) begin
                state <= S_IDLE;
                // A bad stop bit may be a held break; wait for the line to go high again.
                armed <= ~frame_err_next;
              end
            end
            default: ;
          endcase
        end
        if (end_bit) begin
          case (state)
            S_START: state <= S_DATA;
            S_DATA: begin
              if (bit_idx == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? S_PARITY : S_STOP;
              else                              bit_idx <= bit_idx + 4'd1;
            end
            S_PARITY: state <= S_STOP;
            S_STOP:   stop_idx <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  logic [CW-1:0] count;
  logic          full, pop, push_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = (count != '0) && m.m_ready;
  assign push_ok = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push_req && !push_ok;
      if (push_ok) begin
        mem[wr_idx] <= {data_sr, parity_err, frame_err_next};
        wr_idx      <= wr_idx + AW'(1);
      end
      if (pop) rd_idx <= rd_idx + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign m.m_valid = (count != '0);
  assign {m.m_data, m.m_parity_err, m.m_frame_err} = mem[rd_idx];
  assign fifo_count = count;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: 8N1, 8E1 and 8O1 instances at 16 clk per bit; directed frames,
// with expected {data, parity_err, frame_err} queued per instance and checked on each pop.
module tb_uart_rx_framed;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_n = 1'b1;
  logic rx_p = 1'b1;
  logic ovr_n, ovr_e, ovr_o;
  logic [2:0] cnt_n, cnt_e, cnt_o;
  logic [2:0] dbg_n, dbg_e, dbg_o;

  int checks = 0;
  int failures = 0;
  int ovr_cnt = 0;
  logic [9:0] exp_n[$];
  logic [9:0] exp_e[$];
  logic [9:0] exp_o[$];

  always #5 clk = ~clk;

  uart_rx_framed_if #(.DATA_BITS(8)) if_n ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_e ();
  uart_rx_framed_if #(.DATA_BITS(8)) if_o ();

  uart_rx_framed #(.CLOCK_RATE_HZ(1600000), .BAUD_RATE(100000), .PARITY(0)) u_n (
    .clk(clk), .reset(reset), .rx(rx_n), .m(if_n.master),
    .overrun(ovr_n), .fifo_count(cnt_n), .dbg_state(dbg_n));
  uart_rx_framed #(.CLOCK_RATE_HZ(1600000), .BAUD_RATE(100000), .PARITY(1)) u_e (
    .clk(clk), .reset(reset), .rx(rx_p), .m(if_e.master),
    .overrun(ovr_e), .fifo_count(cnt_e), .dbg_state(dbg_e));
  uart_rx_framed #(.CLOCK_RATE_HZ(1600000), .BAUD_RATE(100000), .PARITY(2)) u_o (
    .clk(clk), .reset(reset), .rx(rx_p), .m(if_o.master),
    .overrun(ovr_o), .fifo_count(cnt_o), .dbg_state(dbg_o));

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_rx(input int sel, input logic b);
    if (sel == 0) rx_n = b;
    else          rx_p = b;
  endtask

  // par < 0 sends no parity bit; otherwise par is the parity bit value.
  task automatic send_frame(input int sel, input logic [7:0] d, input int par);
    set_rx(sel, 1'b0); cyc(16);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]); cyc(16);
    end
    if (par >= 0) begin
      set_rx(sel, par[0]); cyc(16);
    end
    set_rx(sel, 1'b1); cyc(16);
    cyc(4);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_n.size() + exp_e.size() + exp_o.size()) != 0 && k < 3000) begin
      cyc(1);
      k++;
    end
    checks++;
    if ((exp_n.size() + exp_e.size() + exp_o.size()) != 0) begin
      failures++;
      $display("FAIL %s drain timeout pending=%0d required=0", nm,
               exp_n.size() + exp_e.size() + exp_o.size());
    end
  endtask

  task automatic pop_cmp(input int sel, input logic [9:0] act);
    logic [9:0] exp;
    checks++;
    if (sel == 0 && exp_n.size() != 0)      exp = exp_n.pop_front();
    else if (sel == 1 && exp_e.size() != 0) exp = exp_e.pop_front();
    else if (sel == 2 && exp_o.size() != 0) exp = exp_o.pop_front();
    else begin
      failures++;
      $display("FAIL frame_unexpected dut=%0d actual=%h required=none", sel, act);
      return;
    end
    if (act !== exp) begin
      failures++;
      $display("FAIL frame dut=%0d actual=%h required=%h", sel, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (if_n.m_valid && if_n.m_ready) pop_cmp(0, {if_n.m_data, if_n.m_parity_err, if_n.m_frame_err});
      if (if_e.m_valid && if_e.m_ready) pop_cmp(1, {if_e.m_data, if_e.m_parity_err, if_e.m_frame_err});
      if (if_o.m_valid && if_o.m_ready) pop_cmp(2, {if_o.m_data, if_o.m_parity_err, if_o.m_frame_err});
      if (ovr_n) ovr_cnt++;
    end
  end

  initial begin
    int k;
    if_n.m_ready = 1'b0;
    if_e.m_ready = 1'b1;
    if_o.m_ready = 1'b1;
    cyc(5);
    reset = 1'b0;
    cyc(1);
    check("rst_valid", int'(if_n.m_valid), 0);
    check("rst_data", int'(if_n.m_data), 0);
    check("rst_perr", int'(if_n.m_parity_err), 0);
    check("rst_ferr", int'(if_n.m_frame_err), 0);
    check("rst_count", int'(cnt_n), 0);
    check("rst_overrun", int'(ovr_n), 0);
    check("rst_state", int'(dbg_n), 0);
    cyc(20);

    // 8N1 single frame, held in the FIFO until released.
    exp_n.push_back({8'hA5, 1'b0, 1'b0});
    send_frame(0, 8'hA5, -1);
    k = 0;
    while (!if_n.m_valid && k < 200) begin cyc(1); k++; end
    check("a5_valid", int'(if_n.m_valid), 1);
    check("a5_count", int'(cnt_n), 1);
    if_n.m_ready = 1'b1;
    wait_drain("a5");
    check("a5_count_after", int'(cnt_n), 0);

    // Parity: 0x07 has odd weight, so parity bit 0 is wrong for even, right for odd.
    exp_e.push_back({8'h07, 1'b1, 1'b0});
    exp_o.push_back({8'h07, 1'b0, 1'b0});
    send_frame(1, 8'h07, 0);
    exp_e.push_back({8'h07, 1'b0, 1'b0});
    exp_o.push_back({8'h07, 1'b1, 1'b0});
    send_frame(1, 8'h07, 1);
    wait_drain("parity");

    // Short glitch is a false start: no frame.
    rx_n = 1'b0; cyc(6);
    rx_n = 1'b1; cyc(200);
    check("glitch_valid", int'(if_n.m_valid), 0);
    check("glitch_count", int'(cnt_n), 0);
    check("glitch_state", int'(dbg_n), 0);

    // Overrun on the fifth frame, then ordered drain.
    if_n.m_ready = 1'b0;
    ovr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_n.push_back({i[7:0], 1'b0, 1'b0});
      send_frame(0, i[7:0], -1);
    end
    cyc(20);
    check("ovr_count", int'(cnt_n), 4);
    check("ovr_pulses", ovr_cnt, 1);
    if_n.m_ready = 1'b1;
    wait_drain("ovr_drain");
    check("ovr_empty", int'(cnt_n), 0);

    // Held break: exactly one framing-error frame, then recovery.
    exp_n.push_back({8'h00, 1'b0, 1'b1});
    rx_n = 1'b0; cyc(30 * 16);
    rx_n = 1'b1; cyc(40);
    exp_n.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(0, 8'h3C, -1);
    wait_drain("break");

    // Reset during data bit 4 drops the partial frame.
    rx_n = 1'b0; cyc(16);
    for (int i = 0; i < 4; i++) begin rx_n = 1'b1; cyc(16); end
    rx_n = 1'b0; cyc(8);
    reset = 1'b1; cyc(3);
    reset = 1'b0; rx_n = 1'b1; cyc(1);
    check("midrst_count", int'(cnt_n), 0);
    check("midrst_valid", int'(if_n.m_valid), 0);
    cyc(200);
    check("midrst_nopush", int'(cnt_n), 0);
    exp_n.push_back({8'h55, 1'b0, 1'b0});
    send_frame(0, 8'h55, -1);
    wait_drain("midrst_55");
    cyc(50);
    check("end_count_n", int'(cnt_n), 0);
    check("end_count_e", int'(cnt_e) + int'(cnt_o), 0);
    check("end_ovr_po", int'(ovr_e) + int'(ovr_o), 0);
    check("end_state_po", int'(dbg_e) + int'(dbg_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
